// File: rtl/selftrig_frame_capture.sv
// selftrig_frame_capture: ring-buffered capture of trigger-aligned frames (marker, timestamp, samples) onto a valid/ready stream
module selftrig_frame_capture #(
  parameter int AW        = 10,
  parameter int PRETRIG   = 64,
  parameter int FRAME_LEN = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] y,
  input  logic               trigger,
  input  logic [63:0]        timestamp,
  output logic [15:0]        dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy,
  output logic [15:0]        trig_dropped,
  output logic               overrun_err
);
  localparam int DEPTH = 2**AW;
  localparam int PW    = $clog2(PRETRIG + 1);
  localparam int FW    = $clog2(FRAME_LEN + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [PW-1:0] PRE       = PW'(PRETRIG);
  localparam logic [AW:0]   U_MAX     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   U_START   = (AW+1)'(PRETRIG + 1);
  localparam logic [FW-1:0] LEN       = FW'(FRAME_LEN);
  localparam logic [FW-1:0] ONE       = FW'(1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
  logic [15:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PW-1:0]  r_fill;
  logic [1:0]     r_state;
  logic [63:0]    r_ts;
  logic [2:0]     r_hidx;
  logic [AW:0]    r_unread;
  logic [FW-1:0]  r_fetch_left, r_load_left;
  logic [15:0]    r_q;
  logic           r_q_vld;
  logic [15:0]    r_dout, r_trig_dropped;
  logic           r_dout_valid, r_dout_last, r_overrun;
  logic           w_armed, w_accept, w_xfer, w_slot, w_ld_hdr, w_ld_dat, w_fetch, w_overrun;
  logic [15:0]    w_hdr_word;
  logic [AW:0]    w_unread_nxt;
  always_comb begin
    w_armed    = r_fill == PRE;
    w_accept   = enable && trigger && r_state == S_IDLE && w_armed;
    w_xfer     = r_dout_valid && dout_ready;
    w_slot     = !r_dout_valid || w_xfer;
    w_ld_hdr   = r_state == S_HDR && w_slot;
    w_ld_dat   = r_state == S_DATA && r_q_vld && r_load_left != '0 && w_slot;
    w_fetch    = r_state != S_IDLE && r_fetch_left != '0 && r_unread != '0 && (!r_q_vld || w_ld_dat);
    w_overrun  = r_state != S_IDLE && enable && r_unread == U_MAX && r_fetch_left != '0;
    w_hdr_word = r_hidx == 3'd0 ? 16'hA5C3 :
                 r_hidx == 3'd1 ? r_ts[63:48] :
                 r_hidx == 3'd2 ? r_ts[47:32] :
                 r_hidx == 3'd3 ? r_ts[31:16] : r_ts[15:0];
    // unread counts written-but-not-fetched samples; pinned at DEPTH once the writer laps the reader
    w_unread_nxt = (enable && !w_fetch) ? (r_unread == U_MAX ? r_unread : r_unread + 1'b1) :
                   (!enable && w_fetch) ? r_unread - 1'b1 : r_unread;
  end
  always_ff @(posedge clk) begin
    if (enable) r_mem[r_wr_ptr] <= y;
    if (w_fetch) r_q <= r_mem[r_rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_fill         <= '0;
      r_state        <= S_IDLE;
      r_ts           <= '0;
      r_hidx         <= '0;
      r_unread       <= '0;
      r_fetch_left   <= '0;
      r_load_left    <= '0;
      r_q_vld        <= 1'b0;
      r_dout         <= '0;
      r_dout_valid   <= 1'b0;
      r_dout_last    <= 1'b0;
      r_trig_dropped <= '0;
      r_overrun      <= 1'b0;
    end else begin
      if (enable) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (enable && !w_armed) r_fill <= r_fill + 1'b1;
      if (enable && trigger && !(r_state == S_IDLE && w_armed) && r_trig_dropped != '1)
        r_trig_dropped <= r_trig_dropped + 1'b1;
      if (w_overrun) r_overrun <= 1'b1;
      if (w_accept) begin
        r_state      <= S_HDR;
        r_ts         <= timestamp;
        r_rd_ptr     <= r_wr_ptr - PRE_OFS;
        r_hidx       <= '0;
        r_unread     <= U_START;
        r_fetch_left <= LEN;
        r_load_left  <= LEN;
        r_q_vld      <= 1'b0;
      end else begin
        r_unread <= w_unread_nxt;
        r_q_vld  <= w_fetch || (r_q_vld && !w_ld_dat);
        if (w_fetch) begin
          r_rd_ptr     <= r_rd_ptr + 1'b1;
          r_fetch_left <= r_fetch_left - 1'b1;
        end
        if (w_ld_hdr) r_hidx <= r_hidx + 1'b1;
        if (w_ld_hdr && r_hidx == 3'd4) r_state <= S_DATA;
        if (w_ld_dat) r_load_left <= r_load_left - 1'b1;
        if (r_state == S_DATA && w_xfer && r_dout_last) r_state <= S_IDLE;
      end
      if (w_ld_hdr || w_ld_dat) begin
        r_dout       <= w_ld_hdr ? w_hdr_word : r_q;
        r_dout_valid <= 1'b1;
        r_dout_last  <= w_ld_dat && r_load_left == ONE;
      end else if (w_xfer) begin
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end
    end
  end
  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign dout_last    = r_dout_last;
  assign busy         = r_state != S_IDLE;
  assign trig_dropped = r_trig_dropped;
  assign overrun_err  = r_overrun;
endmodule

// File: tb/tb_selftrig_frame_capture.sv
// tb_selftrig_frame_capture: directed checks of frame capture with AW=5, PRETRIG=4, FRAME_LEN=16
module tb_selftrig_frame_capture;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, trigger = 1'b0, dout_ready = 1'b0;
  logic [15:0] y = '0;
  logic [63:0] timestamp = '0;
  logic [15:0] dout, trig_dropped;
  logic        dout_valid, dout_last, busy, overrun_err;
  selftrig_frame_capture #(.AW(5), .PRETRIG(4), .FRAME_LEN(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .y(y), .trigger(trigger), .timestamp(timestamp),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .trig_dropped(trig_dropped), .overrun_err(overrun_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [15:0] ramp = '0;
  bit tog = 1'b1;
  int en_mode = 0, rdy_mode = 0, rdy_hold = 0, wb = 0;
  logic [15:0] wq[$];
  bit lq[$];
  int nl = 0, gaps = 0, hold_err = 0;
  bit pend = 1'b0;
  logic [16:0] pw = '0;
  always @(negedge clk) begin
    if (pend && (!dout_valid || {dout_last, dout} != pw)) hold_err++;
    pend = dout_valid && !dout_ready && !reset;
    pw = {dout_last, dout};
    if (busy && !dout_valid) gaps++;
    if (dout_valid && dout_ready) begin
      wq.push_back(dout);
      lq.push_back(dout_last);
      if (dout_last) nl++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic trg);
    enable = (en_mode == 0) || tog;
    trigger = trg;
    y = ramp;
    dout_ready = (rdy_hold > 0) ? 1'b0 : (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk); #1;
    if (enable) ramp++;
    tog = !tog;
    if (rdy_hold > 0) rdy_hold--;
    trigger = 1'b0;
  endtask
  task automatic reset_dut();
    reset = 1'b1; enable = 1'b0; trigger = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; ramp = '0; tog = 1'b1;
  endtask
  task automatic trig_at(input logic [15:0] v, input logic [63:0] ts);
    int k = 0;
    while (!(ramp == v && (en_mode == 0 || tog)) && k < 200) begin cyc(1'b0); k++; end
    timestamp = ts;
    cyc(1'b1);
    timestamp = ~ts;
  endtask
  task automatic wait_last(input string tag, input int budget);
    int n0 = nl;
    int k = 0;
    while (nl == n0 && k < budget) begin cyc(1'b0); k++; end
    chk({tag, "_end"}, 64'(nl - n0), 64'd1);
  endtask
  task automatic chk_frame(input string tag, input logic [15:0] s0, input logic [63:0] ts, input bit data);
    int bad = 0, lbad = 0;
    chk({tag, "_len"}, 64'(wq.size() - wb), 64'd21);
    if (wq.size() - wb == 21) begin
      chk({tag, "_mark"}, 64'(wq[wb]), 64'hA5C3);
      chk({tag, "_ts"}, {wq[wb+1], wq[wb+2], wq[wb+3], wq[wb+4]}, ts);
      for (int i = 0; i < 16; i++) if (wq[wb+5+i] != s0 + 16'(i)) bad++;
      for (int i = 0; i < 21; i++) if (lq[wb+i] != (i == 20)) lbad++;
      if (data) chk({tag, "_data"}, 64'(bad), 64'd0);
      chk({tag, "_last"}, 64'(lbad), 64'd0);
    end
    wb = wq.size();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] v;
    int k, g0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 64'({dout_valid, dout_last, busy, overrun_err}), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_drop", 64'(trig_dropped), 64'd0);
    reset = 1'b0; ramp = '0; tog = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    chk("na_drop", 64'(trig_dropped), 64'd1);
    chk("na_busy", 64'(busy), 64'd0);
    chk("na_noframe", 64'(wq.size()), 64'd0);
    trig_at(16'd10, 64'h0123_4567_89AB_CDEF);
    wait_last("na", 100);
    chk_frame("na", 16'd6, 64'h0123_4567_89AB_CDEF, 1'b1);
    reset_dut();
    g0 = gaps;
    trig_at(16'd20, 64'h0011_2233_4455_6677);
    chk("mk_early", 64'(dout_valid), 64'd0);
    cyc(1'b0);
    chk("mk_valid", 64'(dout_valid), 64'd1);
    chk("mk_word", 64'(dout), 64'hA5C3);
    chk("mk_busy", 64'(busy), 64'd1);
    wait_last("basic", 100);
    chk_frame("basic", 16'd16, 64'h0011_2233_4455_6677, 1'b1);
    chk("basic_b2b", 64'(gaps - g0), 64'd1);
    reset_dut();
    trig_at(16'd20, 64'hDEAD_BEEF_CAFE_F00D);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("bd_drop", 64'(trig_dropped), 64'd1);
    wait_last("bd", 100);
    chk_frame("bd", 16'd16, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    v = ramp;
    trig_at(v, 64'h1111_2222_3333_4444);
    chk("bd_acc", 64'(busy), 64'd1);
    k = 0;
    while (!dout_last && k < 100) begin cyc(1'b0); k++; end
    cyc(1'b1);
    chk("bd_last_drop", 64'(trig_dropped), 64'd2);
    chk_frame("bd2", v - 16'd4, 64'h1111_2222_3333_4444, 1'b1);
    repeat (3) cyc(1'b0);
    chk("bd_idle", 64'(busy), 64'd0);
    reset_dut();
    en_mode = 1;
    g0 = gaps;
    trig_at(16'd20, 64'h5555_6666_7777_8888);
    wait_last("gate", 300);
    chk_frame("gate", 16'd16, 64'h5555_6666_7777_8888, 1'b1);
    chk("gate_gap", 64'((gaps - g0) > 1), 64'd1);
    en_mode = 0;
    reset_dut();
    trig_at(16'd20, 64'h9999_AAAA_BBBB_CCCC);
    rdy_hold = 40;
    wait_last("ovr", 200);
    chk_frame("ovr", 16'd16, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    chk("ovr_flag", 64'(overrun_err), 64'd1);
    repeat (5) cyc(1'b0);
    chk("ovr_sticky", 64'(overrun_err), 64'd1);
    reset_dut();
    chk("ovr_clr", 64'(overrun_err), 64'd0);
    rdy_mode = 1;
    trig_at(16'd20, 64'hFEDC_BA98_7654_3210);
    wait_last("rnd", 400);
    chk_frame("rnd", 16'd16, 64'hFEDC_BA98_7654_3210, 1'b1);
    chk("rnd_ovr", 64'(overrun_err), 64'd0);
    rdy_mode = 0;
    reset_dut();
    trig_at(16'd20, 64'h0F0F_0F0F_F0F0_F0F0);
    cyc(1'b1);
    chk("rm_pre_drop", 64'(trig_dropped), 64'd1);
    k = 0;
    while (wq.size() - wb < 10 && k < 100) begin cyc(1'b0); k++; end
    chk("rm_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    chk("rm_valid", 64'(dout_valid), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_cnt", 64'({trig_dropped, dout_last, overrun_err}), 64'd0);
    wb = wq.size();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    chk("rm_drop", 64'(trig_dropped), 64'd1);
    chk("rm_idle", 64'(busy), 64'd0);
    chk("rm_noframe", 64'(wq.size() - wb), 64'd0);
    chk("hold", 64'(hold_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
